// File: rtl/dyn_clock_pkg.sv
// Shared types and constants for the multiplexed hours/minutes/seconds clock:
// BCD digit type, seven-segment patterns (gfedcba, active-high), idle commons
// value and the scan-slot index of each time digit.
package dyn_clock_pkg;

    typedef logic [3:0] bcd_t;

    localparam logic [7:0] COM_IDLE  = 8'hFF;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_0     = 7'h3f;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5b;
    localparam logic [6:0] SEG_3     = 7'h4f;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6d;
    localparam logic [6:0] SEG_6     = 7'h7d;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7f;
    localparam logic [6:0] SEG_9     = 7'h6f;

    // Scan slot of each digit; slot 0 is the rightmost digit on the board.
    localparam logic [2:0] IDX_SEC_01 = 3'd0;
    localparam logic [2:0] IDX_SEC_10 = 3'd1;
    localparam logic [2:0] IDX_MIN_01 = 3'd2;
    localparam logic [2:0] IDX_MIN_10 = 3'd3;
    localparam logic [2:0] IDX_HR_01  = 3'd4;
    localparam logic [2:0] IDX_HR_10  = 3'd5;

    // BCD digit to segment pattern; codes 10..15 show nothing.
    function automatic logic [6:0] seg_encode(input bcd_t digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter wrapping at MOD. The step input is 0, 1 or 2 so the
// hour counter can absorb a minute carry and a manual increment in one edge.
// carry is combinational: it flags that the step applied this edge wraps.
module bcd_mod_counter
    import dyn_clock_pkg::*;
#(
    parameter int MOD = 60
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic [1:0] inc,
    input  logic       clear,
    output bcd_t       ones,
    output bcd_t       tens,
    output logic       carry
);

    bcd_t       ones_reg;
    bcd_t       tens_reg;
    logic [6:0] value_cur;
    logic [6:0] value_sum;
    logic [6:0] value_next;

    // Work in binary (values stay below 100) and split back into BCD digits.
    assign value_cur  = 7'(tens_reg) * 7'd10 + 7'(ones_reg);
    assign value_sum  = value_cur + 7'(inc);
    assign carry      = !clear && (value_sum >= 7'(MOD));
    assign value_next = carry ? (value_sum - 7'(MOD)) : value_sum;

    // Digit registers; clear dominates any step arriving in the same cycle.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            ones_reg <= '0;
            tens_reg <= '0;
        end else if (clear) begin
            ones_reg <= '0;
            tens_reg <= '0;
        end else if (inc != 2'd0) begin
            ones_reg <= 4'(value_next % 7'd10);
            tens_reg <= 4'(value_next / 7'd10);
        end
    end

    assign ones = ones_reg;
    assign tens = tens_reg;

endmodule

// File: rtl/dyn_hms_clock.sv
// Time-of-day clock (BCD HH:MM:SS) with a multiplexed seven-segment driver
// for the 8-digit board module. Optional build macro DYN_HMS_CLOCK_BLANK_EN
// blanks a leading zero in the most significant displayed digit.
module dyn_hms_clock
    import dyn_clock_pkg::*;
#(
    parameter int CLK_HZ     = 25_000_000,
    parameter int SCAN_HZ    = 1000,
    parameter int NUM_DIGITS = 6,
    parameter int HOUR_MOD   = 24
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       RUN,
    input  logic       INC_MIN,
    input  logic       INC_HOUR,
    output logic [6:0] SEG_DEC,
    output logic [7:0] COM,
    output logic       SEC_TICK
);

    localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int PW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int SW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [PW-1:0] sec_presc_reg;
    logic          sec_wrap;
    logic          sec_step;
    logic          sec_tick_reg;

    bcd_t sec_01, sec_10, min_01, min_10, hr_01, hr_10;
    logic sec_carry, min_carry, hr_carry_unused;
    logic min_step, min_to_hr;
    logic [1:0] hr_step;

    logic [SW-1:0] scan_presc_reg;
    logic          scan_strobe;
    logic [2:0]    scan_idx_reg;
    logic [7:0]    com_reg;
    logic [6:0]    seg_reg;
    logic [7:0]    com_next;
    logic [6:0]    seg_next;
    bcd_t          digit_sel;
    logic          digit_blank;

    // A second elapses when the prescaler is at terminal count with RUN high.
    // A minute increment in the same cycle swallows that second entirely.
    assign sec_wrap = RUN && (sec_presc_reg == PW'(CLK_HZ - 1));
    assign sec_step = sec_wrap && !INC_MIN;

    // Second prescaler: frozen while RUN is low, restarted by a minute set.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            sec_presc_reg <= '0;
        end else if (INC_MIN) begin
            sec_presc_reg <= '0;
        end else if (RUN) begin
            sec_presc_reg <= sec_wrap ? '0 : sec_presc_reg + PW'(1);
        end
    end

    // SEC_TICK goes high together with the new seconds value.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            sec_tick_reg <= 1'b0;
        end else begin
            sec_tick_reg <= sec_step;
        end
    end

    // A manual minute step never ripples into the hours; a seconds carry does.
    // Hours may see a carry and INC_HOUR together and then advance by two.
    assign min_step  = INC_MIN | sec_carry;
    assign min_to_hr = min_carry && !INC_MIN;
    assign hr_step   = {1'b0, INC_HOUR} + {1'b0, min_to_hr};

    bcd_mod_counter #(.MOD(60)) u_sec (
        .CLK   (CLK),
        .CLR   (CLR),
        .inc   ({1'b0, sec_step}),
        .clear (INC_MIN),
        .ones  (sec_01),
        .tens  (sec_10),
        .carry (sec_carry)
    );

    bcd_mod_counter #(.MOD(60)) u_min (
        .CLK   (CLK),
        .CLR   (CLR),
        .inc   ({1'b0, min_step}),
        .clear (1'b0),
        .ones  (min_01),
        .tens  (min_10),
        .carry (min_carry)
    );

    bcd_mod_counter #(.MOD(HOUR_MOD)) u_hr (
        .CLK   (CLK),
        .CLR   (CLR),
        .inc   (hr_step),
        .clear (1'b0),
        .ones  (hr_01),
        .tens  (hr_10),
        .carry (hr_carry_unused)
    );

    assign scan_strobe = (scan_presc_reg == SW'(SCAN_DIV - 1));

    // Scan prescaler runs regardless of RUN so the display never freezes.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            scan_presc_reg <= '0;
        end else begin
            scan_presc_reg <= scan_strobe ? '0 : scan_presc_reg + SW'(1);
        end
    end

    // Digit selected by the slot about to be driven.
    always_comb begin
        digit_sel = '0;
        case (scan_idx_reg)
            IDX_SEC_01: digit_sel = sec_01;
            IDX_SEC_10: digit_sel = sec_10;
            IDX_MIN_01: digit_sel = min_01;
            IDX_MIN_10: digit_sel = min_10;
            IDX_HR_01:  digit_sel = hr_01;
            IDX_HR_10:  digit_sel = hr_10;
            default:    digit_sel = '0;
        endcase
    end

`ifdef DYN_HMS_CLOCK_BLANK_EN
    assign digit_blank = (scan_idx_reg == 3'(NUM_DIGITS - 1)) && (digit_sel == 4'd0);
`else
    assign digit_blank = 1'b0;
`endif

    assign seg_next = digit_blank ? SEG_BLANK : seg_encode(digit_sel);

    // One-hot active-low common for the current slot; unused slots stay off.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_com
            if (gi < NUM_DIGITS) begin : g_active
                assign com_next[gi] = (scan_idx_reg != 3'(gi));
            end else begin : g_idle
                assign com_next[gi] = 1'b1;
            end
        end
    endgenerate

    // COM and SEG_DEC load on the same strobe so digit and pattern always agree.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            scan_idx_reg <= '0;
            com_reg      <= COM_IDLE;
            seg_reg      <= SEG_BLANK;
        end else if (scan_strobe) begin
            com_reg      <= com_next;
            seg_reg      <= seg_next;
            scan_idx_reg <= (scan_idx_reg == 3'(NUM_DIGITS - 1)) ? 3'd0 : scan_idx_reg + 3'd1;
        end
    end

    assign COM      = com_reg;
    assign SEG_DEC  = seg_reg;
    assign SEC_TICK = sec_tick_reg;

endmodule

// File: tb/tb_dyn_hms_clock.sv
// Bench for dyn_hms_clock: three instances (6 digits/24 h, 4 digits/24 h,
// 6 digits/12 h) share one stimulus and are compared every cycle against a
// reference model that tracks time as seconds-since-midnight.
module tb_dyn_hms_clock;

    localparam int HZ   = 100;
    localparam int SCAN = 50;
    localparam int DIV  = HZ / SCAN;

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic run      = 1'b0;
    logic inc_min  = 1'b0;
    logic inc_hour = 1'b0;

    logic [6:0] seg_a, seg_b, seg_c;
    logic [7:0] com_a, com_b, com_c;
    logic       tick_a, tick_b, tick_c;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dyn_hms_clock #(.CLK_HZ(HZ), .SCAN_HZ(SCAN), .NUM_DIGITS(6), .HOUR_MOD(24)) u_dut_a (
        .CLK(clk), .CLR(rst_n), .RUN(run), .INC_MIN(inc_min), .INC_HOUR(inc_hour),
        .SEG_DEC(seg_a), .COM(com_a), .SEC_TICK(tick_a)
    );
    dyn_hms_clock #(.CLK_HZ(HZ), .SCAN_HZ(SCAN), .NUM_DIGITS(4), .HOUR_MOD(24)) u_dut_b (
        .CLK(clk), .CLR(rst_n), .RUN(run), .INC_MIN(inc_min), .INC_HOUR(inc_hour),
        .SEG_DEC(seg_b), .COM(com_b), .SEC_TICK(tick_b)
    );
    dyn_hms_clock #(.CLK_HZ(HZ), .SCAN_HZ(SCAN), .NUM_DIGITS(6), .HOUR_MOD(12)) u_dut_c (
        .CLK(clk), .CLR(rst_n), .RUN(run), .INC_MIN(inc_min), .INC_HOUR(inc_hour),
        .SEG_DEC(seg_c), .COM(com_c), .SEC_TICK(tick_c)
    );

    logic [7:0] obs_com [3];
    logic [6:0] obs_seg [3];
    logic       obs_tick [3];
    assign obs_com[0] = com_a;  assign obs_seg[0] = seg_a;  assign obs_tick[0] = tick_a;
    assign obs_com[1] = com_b;  assign obs_seg[1] = seg_b;  assign obs_tick[1] = tick_b;
    assign obs_com[2] = com_c;  assign obs_seg[2] = seg_c;  assign obs_tick[2] = tick_c;

    // ---------------- reference model ----------------
    int         m_t24 = 0;     // seconds since midnight, 24 h wrap
    int         m_t12 = 0;     // seconds since midnight, 12 h wrap
    int         m_cnt = 0;     // running cycles spent in the current second
    int         m_edges = 0;   // clock edges since reset release
    int         m_k = 0;
    logic       m_tick = 1'b0;
    logic [7:0] m_com [3] = '{8'hFF, 8'hFF, 8'hFF};
    logic [6:0] m_seg [3] = '{7'h00, 7'h00, 7'h00};

    function automatic int nd_of(input int i);
        return (i == 1) ? 4 : 6;
    endfunction

    function automatic int min_plus(input int t);
        return (t / 3600) * 3600 + (((t / 60) % 60 + 1) % 60) * 60;
    endfunction

    function automatic logic [6:0] ref_seg(input int t, input int k, input int nd);
        int d;
        case (k)
            0:       d = (t % 60) % 10;
            1:       d = (t % 60) / 10;
            2:       d = ((t / 60) % 60) % 10;
            3:       d = ((t / 60) % 60) / 10;
            4:       d = (t / 3600) % 10;
            default: d = (t / 3600) / 10;
        endcase
`ifdef DYN_HMS_CLOCK_BLANK_EN
        if (k == nd - 1 && d == 0) return 7'h00;
`else
        if (nd < 0) return 7'h00;
`endif
        case (d)
            0: return 7'h3f;  1: return 7'h06;  2: return 7'h5b;  3: return 7'h4f;
            4: return 7'h66;  5: return 7'h6d;  6: return 7'h7d;  7: return 7'h07;
            8: return 7'h7f;  default: return 7'h6f;
        endcase
    endfunction

    always begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_t24 = 0; m_t12 = 0; m_cnt = 0; m_edges = 0; m_tick = 1'b0;
            for (int i = 0; i < 3; i++) begin
                m_com[i] = 8'hFF;
                m_seg[i] = 7'h00;
            end
        end else begin
            // display shows the time held before this edge
            m_edges++;
            if (m_edges % DIV == 0) begin
                for (int i = 0; i < 3; i++) begin
                    m_k = (m_edges / DIV - 1) % nd_of(i);
                    m_com[i] = ~(8'h01 << m_k);
                    m_seg[i] = ref_seg((i == 2) ? m_t12 : m_t24, m_k, nd_of(i));
                end
            end
            m_tick = 1'b0;
            if (inc_min) m_cnt = 0;
            else if (run) begin
                if (m_cnt == HZ - 1) begin
                    m_cnt = 0;
                    m_tick = 1'b1;
                end else m_cnt++;
            end
            if (m_tick) begin
                m_t24 = (m_t24 + 1) % 86400;
                m_t12 = (m_t12 + 1) % 43200;
            end
            if (inc_min) begin
                m_t24 = min_plus(m_t24);
                m_t12 = min_plus(m_t12);
            end
            if (inc_hour) begin
                m_t24 = (m_t24 + 3600) % 86400;
                m_t12 = (m_t12 + 3600) % 43200;
            end
        end
    end

    // ---------------- tests ----------------
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({obs_com[i], obs_seg[i], obs_tick[i]} !== {8'hFF, 7'h00, 1'b0}) begin
                n_errors++;
                $display("FAIL reset dut%0d com/seg/tick got %h/%h/%b exp ff/00/0", i, obs_com[i], obs_seg[i], obs_tick[i]);
            end
        end
        rst_n = 1'b1;
        run   = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if ({obs_com[i], obs_seg[i], obs_tick[i]} !== {m_com[i], m_seg[i], m_tick}) begin
                    n_errors++;
                    $display("FAIL first_scan dut%0d t=%0t got %h/%h/%b exp %h/%h/%b", i, $time, obs_com[i], obs_seg[i], obs_tick[i], m_com[i], m_seg[i], m_tick);
                end
            end
        end
    endtask

    task automatic test_seconds(input string name, input int ncycles);
        for (int c = 0; c < ncycles; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if ({obs_com[i], obs_seg[i], obs_tick[i]} !== {m_com[i], m_seg[i], m_tick}) begin
                    n_errors++;
                    $display("FAIL %s dut%0d t=%0t got %h/%h/%b exp %h/%h/%b", name, i, $time, obs_com[i], obs_seg[i], obs_tick[i], m_com[i], m_seg[i], m_tick);
                end
            end
        end
    endtask

    task automatic test_clr_mid_scan();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({obs_com[i], obs_seg[i], obs_tick[i]} !== {8'hFF, 7'h00, 1'b0}) begin
                n_errors++;
                $display("FAIL clr_async dut%0d got %h/%h/%b exp ff/00/0", i, obs_com[i], obs_seg[i], obs_tick[i]);
            end
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if ({obs_com[i], obs_seg[i], obs_tick[i]} !== {m_com[i], m_seg[i], m_tick}) begin
                    n_errors++;
                    $display("FAIL clr_after dut%0d t=%0t got %h/%h/%b exp %h/%h/%b", i, $time, obs_com[i], obs_seg[i], obs_tick[i], m_com[i], m_seg[i], m_tick);
                end
            end
        end
    endtask

    task automatic test_hour_carry();
        int waited = 0;
        // 59 minute pulses, run through 59:59 -> 01:00:00, 59 more, then
        // INC_HOUR together with the 01:59:59 carry gives 03:00:00
        for (int c = 0; c < 118 + 6050 + 118; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if ({obs_com[i], obs_seg[i], obs_tick[i]} !== {m_com[i], m_seg[i], m_tick}) begin
                    n_errors++;
                    $display("FAIL hour_carry dut%0d t=%0t got %h/%h/%b exp %h/%h/%b", i, $time, obs_com[i], obs_seg[i], obs_tick[i], m_com[i], m_seg[i], m_tick);
                end
            end
            inc_min = (c < 118 || c >= 118 + 6050) && (c % 2 == 0);
        end
        inc_min = 1'b0;
        while (!(m_t24 == 3600 + 59 * 60 + 59 && m_cnt == HZ - 1) && waited < 7000) begin
            @(negedge clk);
            waited++;
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if ({obs_com[i], obs_seg[i], obs_tick[i]} !== {m_com[i], m_seg[i], m_tick}) begin
                    n_errors++;
                    $display("FAIL hour_wait dut%0d t=%0t got %h/%h/%b exp %h/%h/%b", i, $time, obs_com[i], obs_seg[i], obs_tick[i], m_com[i], m_seg[i], m_tick);
                end
            end
        end
        n_checks++;
        if (waited >= 7000) begin
            n_errors++;
            $display("FAIL hour_wait_timeout waited %0d cycles limit 7000", waited);
        end
        inc_hour = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            inc_hour = 1'b0;
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if ({obs_com[i], obs_seg[i], obs_tick[i]} !== {m_com[i], m_seg[i], m_tick}) begin
                    n_errors++;
                    $display("FAIL hour_plus2 dut%0d t=%0t got %h/%h/%b exp %h/%h/%b", i, $time, obs_com[i], obs_seg[i], obs_tick[i], m_com[i], m_seg[i], m_tick);
                end
            end
        end
    endtask

    task automatic test_run_gap();
        int waited = 0;
        int gap = 0;
        while (tick_a !== 1'b1 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (waited >= 300) begin
            n_errors++;
            $display("FAIL run_gap_sync no SEC_TICK within %0d cycles", waited);
        end
        do begin
            @(negedge clk);
            gap++;
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if ({obs_com[i], obs_seg[i], obs_tick[i]} !== {m_com[i], m_seg[i], m_tick}) begin
                    n_errors++;
                    $display("FAIL run_gap dut%0d t=%0t got %h/%h/%b exp %h/%h/%b", i, $time, obs_com[i], obs_seg[i], obs_tick[i], m_com[i], m_seg[i], m_tick);
                end
            end
            run = !(gap >= 40 && gap < 77);
        end while (tick_a !== 1'b1 && gap < 400);
        run = 1'b1;
        n_checks++;
        if (gap != HZ + 37) begin
            n_errors++;
            $display("FAIL run_gap_period tick interval got %0d exp %0d", gap, HZ + 37);
        end
    endtask

    task automatic test_inc_min_on_tick();
        int waited = 0;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            inc_min = (c % 2 == 0);
        end
        inc_min = 1'b0;
        while (!(m_t24 == 5 * 60 + 59 && m_cnt == HZ - 1) && waited < 7000) begin
            @(negedge clk);
            waited++;
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if ({obs_com[i], obs_seg[i], obs_tick[i]} !== {m_com[i], m_seg[i], m_tick}) begin
                    n_errors++;
                    $display("FAIL min_tick_wait dut%0d t=%0t got %h/%h/%b exp %h/%h/%b", i, $time, obs_com[i], obs_seg[i], obs_tick[i], m_com[i], m_seg[i], m_tick);
                end
            end
        end
        n_checks++;
        if (waited >= 7000) begin
            n_errors++;
            $display("FAIL min_tick_timeout waited %0d cycles limit 7000", waited);
        end
        inc_min = 1'b1;
        @(negedge clk);
        inc_min = 1'b0;
        n_checks++;
        if (tick_a !== 1'b0) begin
            n_errors++;
            $display("FAIL min_tick_no_pulse SEC_TICK got %b exp 0", tick_a);
        end
        for (int c = 0; c < 250; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if ({obs_com[i], obs_seg[i], obs_tick[i]} !== {m_com[i], m_seg[i], m_tick}) begin
                    n_errors++;
                    $display("FAIL min_tick_after dut%0d t=%0t got %h/%h/%b exp %h/%h/%b", i, $time, obs_com[i], obs_seg[i], obs_tick[i], m_com[i], m_seg[i], m_tick);
                end
            end
        end
    endtask

    task automatic test_day_wrap();
        do_reset();
        // 23 hour pulses then 59 minute pulses: 23:59:00 (11:59:00 on 12 h)
        for (int c = 0; c < 2 * (23 + 59) + 6100; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if ({obs_com[i], obs_seg[i], obs_tick[i]} !== {m_com[i], m_seg[i], m_tick}) begin
                    n_errors++;
                    $display("FAIL day_wrap dut%0d t=%0t got %h/%h/%b exp %h/%h/%b", i, $time, obs_com[i], obs_seg[i], obs_tick[i], m_com[i], m_seg[i], m_tick);
                end
            end
            inc_hour = (c < 46) && (c % 2 == 0);
            inc_min  = (c >= 46) && (c < 2 * (23 + 59)) && (c % 2 == 0);
        end
        inc_hour = 1'b0;
        inc_min  = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if ({obs_com[i], obs_seg[i], obs_tick[i]} !== {m_com[i], m_seg[i], m_tick}) begin
                    n_errors++;
                    $display("FAIL random dut%0d t=%0t got %h/%h/%b exp %h/%h/%b", i, $time, obs_com[i], obs_seg[i], obs_tick[i], m_com[i], m_seg[i], m_tick);
                end
            end
            run      = ($urandom_range(0, 9) != 0);
            inc_min  = ($urandom_range(0, 399) == 0);
            inc_hour = ($urandom_range(0, 199) == 0);
            if (run && m_cnt == HZ - 1) begin
                inc_min  = ($urandom_range(0, 2) == 0);
                inc_hour = ($urandom_range(0, 2) == 0);
            end
        end
        run      = 1'b1;
        inc_min  = 1'b0;
        inc_hour = 1'b0;
    endtask

    initial begin
        test_reset();
        test_seconds("count_to_7", 740);
        test_clr_mid_scan();
        test_seconds("count_to_10", 1100);
        test_hour_carry();
        test_run_gap();
        test_inc_min_on_tick();
        test_day_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not complete by t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
